// File: rtl/seg_decode_pkg.sv
// seg_decode_pkg: shared 7-segment pattern table (active-high gfedcba) and capture FSM states.
package seg_decode_pkg;
   localparam int SEG_W = 7;
   localparam int NIB_W = 4;
   localparam logic [SEG_W-1:0] SEG_PATTERN [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };
   typedef enum logic {CAP_IDLE, CAP_OFFER} cap_state_t;
endpackage

// File: rtl/segment_to_nibble.sv
// segment_to_nibble: decodes one active-high gfedcba pattern to a nibble; unknown patterns give err=1, nib=0.
module segment_to_nibble
   import seg_decode_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output logic [NIB_W-1:0] nib,
   output logic             err
);
   always_comb begin
      nib = '0;
      err = 1'b1;
      for (int i = 0; i < 16; i++)
         if (seg == SEG_PATTERN[i]) begin
            nib = NIB_W'(i);
            err = 1'b0;
         end
   end
endmodule

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: decodes a raw 7-segment bus once it has settled and offers each new value on valid/ready.
// Define SEG_CAPTURE_ERR_COUNT_EN to add the saturating err_count output.
module seven_segment_capture
   import seg_decode_pkg::*;
#(
   parameter int NUM_DIGITS     = 6,
   parameter int STABLE_CYCLES  = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [SEG_W*NUM_DIGITS-1:0] hex_in,
   output logic [NIB_W*NUM_DIGITS-1:0] value_out,
   output logic [NUM_DIGITS-1:0]       digit_err,
   output logic                        value_valid,
   input  logic                        value_ready
`ifdef SEG_CAPTURE_ERR_COUNT_EN
  ,output logic [7:0]                  err_count
`endif
);
   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
   logic [SEG_W*NUM_DIGITS-1:0] hex_q;
   logic [7:0]                  stable_cnt;
   logic                        first_flag;
   logic [NIB_W*NUM_DIGITS-1:0] dec_val;
   logic [NUM_DIGITS-1:0]       dec_err;
   logic                        go, load;
   cap_state_t                  state, state_nxt;

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
      segment_to_nibble u_dec (
         .seg(hex_q[SEG_W*d +: SEG_W] ^ {SEG_W{SEG_ACTIVE_LOW}}),
         .nib(dec_val[NIB_W*d +: NIB_W]),
         .err(dec_err[d])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hex_q      <= '0;
         stable_cnt <= '0;
      end else begin
         hex_q      <= hex_in;
         stable_cnt <= (hex_in != hex_q) ? 8'd0 :
                       (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + 8'd1;
      end
   end

   // The first offer after reset is forced, later ones only when the decode differs from what was last offered.
   assign go = (stable_cnt == STABLE_MAX) &&
               (first_flag || dec_val != value_out || dec_err != digit_err);

   always_ff @(posedge clk) begin
      if (reset) state <= CAP_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = (state == CAP_IDLE) ? (go ? CAP_OFFER : CAP_IDLE) :
                  (value_ready ? CAP_IDLE : CAP_OFFER);
   end

   always_comb begin
      load        = (state == CAP_IDLE) && go;
      value_valid = (state == CAP_OFFER);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_out  <= '0;
         digit_err  <= '0;
         first_flag <= 1'b1;
      end else if (load) begin
         value_out  <= dec_val;
         digit_err  <= dec_err;
         first_flag <= 1'b0;
      end
   end

`ifdef SEG_CAPTURE_ERR_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         err_count <= '0;
      else if (load && |dec_err && err_count != 8'hFF)
         err_count <= err_count + 8'd1;
   end
`endif
endmodule
